// File: rtl/pu_im_loader_pkg.sv
// ============================================================================
//  Module  : pu_im_loader_pkg
//  Brief   : Shared types and helpers for the instruction-memory loader.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package pu_im_loader_pkg;

    localparam int IM_ADDR_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    // Where to go once both length bytes are known.
    function automatic state_t hdr_next_state(input logic [15:0] len,
                                              input logic [15:0] max_len);
        if (len > max_len) begin
            return ST_ERR;
        end
        if (len == 16'd0) begin
            return ST_CSUM;
        end
        return ST_DATA;
    endfunction

    function automatic logic is_loading(input state_t s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pu_im_loader.sv
// ============================================================================
//  Module  : pu_im_loader
//  Brief   : Framed byte stream (len16 LE, payload, XOR csum) to IM write port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pu_im_loader
    import pu_im_loader_pkg::*;
#(
    parameter int ADDR_W    = IM_ADDR_W,
    parameter int MAX_BYTES = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              byte_valid_in,
    input  logic [7:0]        byte_in,
    output logic              byte_ready_out,
    output logic              we_out,
    output logic [ADDR_W-1:0] waddr_out,
    output logic [7:0]        wdata_out,
    output logic              cpu_hold_out,
    output logic              done_out,
    output logic              err_out
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    // One bit wider than the address so a full-size payload can be counted.
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;

    logic              accept;
    logic [15:0]       count_next;

    assign accept     = byte_valid_in && byte_ready_out;
    assign count_next = 16'(addr_q) + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_in) begin
                    state_d = ST_HDR0;
                    len_d   = '0;
                    addr_d  = '0;
                    csum_d  = '0;
                end
            end
            ST_HDR0: begin
                if (accept) begin
                    len_d[7:0] = byte_in;
                    state_d    = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (accept) begin
                    len_d[15:8] = byte_in;
                    state_d     = hdr_next_state({byte_in, len_q[7:0]}, MAX_LEN);
                end
            end
            ST_DATA: begin
                if (accept) begin
                    csum_d  = csum_q ^ byte_in;
                    we_d    = 1'b1;
                    waddr_d = addr_q[ADDR_W-1:0];
                    wdata_d = byte_in;
                    addr_d  = addr_q + 1'b1;
                    if (count_next == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (byte_in == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags decode straight from state so hold drops on the same edge done/err rise.
    assign byte_ready_out = is_loading(state_q);
    assign cpu_hold_out   = is_loading(state_q);
    assign done_out       = (state_q == ST_DONE);
    assign err_out        = (state_q == ST_ERR);
    assign we_out         = we_q;
    assign waddr_out      = waddr_q;
    assign wdata_out      = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_pu_im_loader.sv
// ============================================================================
//  Module  : tb_pu_im_loader
//  Brief   : Directed self-checking bench for pu_im_loader.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pu_im_loader;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_in = 1'b0;
    logic              byte_valid_in = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_ready_out;
    logic              we_out;
    logic [ADDR_W-1:0] waddr_out;
    logic [7:0]        wdata_out;
    logic              cpu_hold_out;
    logic              done_out;
    logic              err_out;

    pu_im_loader #(.ADDR_W(ADDR_W), .MAX_BYTES(2048)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_in      (start_in),
        .byte_valid_in (byte_valid_in),
        .byte_in       (byte_in),
        .byte_ready_out(byte_ready_out),
        .we_out        (we_out),
        .waddr_out     (waddr_out),
        .wdata_out     (wdata_out),
        .cpu_hold_out  (cpu_hold_out),
        .done_out      (done_out),
        .err_out       (err_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned ncyc = 0;

    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [7:0]        wr_data_q [$];
    int unsigned       wr_cyc_q  [$];
    int unsigned       acc_q     [$];
    logic [7:0]        sq        [$];
    int                gq        [$];
    logic [ADDR_W-1:0] exp_a     [$];
    logic [7:0]        exp_d     [$];

    always @(posedge clk) ncyc <= ncyc + 1;

    always @(negedge clk) begin
        if (we_out === 1'b1) begin
            wr_addr_q.push_back(waddr_out);
            wr_data_q.push_back(wdata_out);
            wr_cyc_q.push_back(ncyc);
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        acc_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b);
        int t;
        byte_in       = b;
        byte_valid_in = 1'b1;
        t = 0;
        while (byte_ready_out !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: byte_ready_out=%b after %0d cycles, required 1", byte_ready_out, t);
        end else begin
            acc_q.push_back(ncyc);
            @(negedge clk);
        end
        byte_valid_in = 1'b0;
    endtask

    // Sends sq[] with gq[i] idle cycles before byte i; optional start pulse in gap of byte start_at.
    task automatic send_stream(input int start_at);
        for (int i = 0; i < sq.size(); i++) begin
            int g;
            g = (i < gq.size()) ? gq[i] : 0;
            for (int k = 0; k < g; k++) begin
                start_in = (i == start_at) && (k == 0);
                @(negedge clk);
            end
            start_in = 1'b0;
            send_byte(sq[i]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (byte_ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", byte_ready_out); end
        n_tests++; if (we_out !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b required 0", we_out); end
        n_tests++; if (waddr_out !== '0) begin n_fail++; $display("FAIL reset_waddr: got %h required 0", waddr_out); end
        n_tests++; if (wdata_out !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h required 00", wdata_out); end
        n_tests++; if (cpu_hold_out !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b required 0", cpu_hold_out); end
        n_tests++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done_out); end
        n_tests++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_good_load(input string tag);
        n_tests++;
        if (wr_addr_q.size() != 4) begin
            n_fail++;
            $display("FAIL %s_wcount: got %0d writes required 4", tag, wr_addr_q.size());
        end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            n_tests++;
            if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL %s_write%0d: got (%h,%h) required (%h,%h)", tag, i, wr_addr_q[i], wr_data_q[i], exp_a[i], exp_d[i]);
            end
            n_tests++;
            if (acc_q.size() == 7 && wr_cyc_q[i] !== acc_q[i+2] + 1) begin
                n_fail++;
                $display("FAIL %s_wtiming%0d: write cycle %0d required %0d", tag, i, wr_cyc_q[i], acc_q[i+2] + 1);
            end
        end
        n_tests++; if (done_out !== 1'b1) begin n_fail++; $display("FAIL %s_done: got %b required 1", tag, done_out); end
        n_tests++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL %s_err: got %b required 0", tag, err_out); end
        n_tests++; if (cpu_hold_out !== 1'b0) begin n_fail++; $display("FAIL %s_hold: got %b required 0", tag, cpu_hold_out); end
        n_tests++; if (byte_ready_out !== 1'b0) begin n_fail++; $display("FAIL %s_ready: got %b required 0", tag, byte_ready_out); end
        n_tests++; if (waddr_out !== 11'd3 || wdata_out !== 8'h00) begin n_fail++; $display("FAIL %s_hold_addr: got (%h,%h) required (003,00)", tag, waddr_out, wdata_out); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        sq    = '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
        gq    = '{};
        exp_a = '{11'd0, 11'd1, 11'd2, 11'd3};
        exp_d = '{8'h13, 8'h05, 8'hA0, 8'h00};
        pulse_start();
        n_tests++; if (cpu_hold_out !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_start: got %b required 1", cpu_hold_out); end
        send_stream(-1);
        check_good_load("b2b");
        for (int i = 1; i < wr_cyc_q.size(); i++) begin
            n_tests++;
            if (wr_cyc_q[i] !== wr_cyc_q[i-1] + 1) begin
                n_fail++;
                $display("FAIL b2b_consecutive%0d: cycle %0d required %0d", i, wr_cyc_q[i], wr_cyc_q[i-1] + 1);
            end
        end
    endtask

    task automatic test_gaps();
        clear_logs();
        sq    = '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
        gq    = '{2, 0, 3, 5, 1, 4, 2};
        exp_a = '{11'd0, 11'd1, 11'd2, 11'd3};
        exp_d = '{8'h13, 8'h05, 8'hA0, 8'h00};
        pulse_start();
        send_stream(3);  // stray start mid-load must be ignored
        check_good_load("gaps");
    endtask

    task automatic test_bad_csum();
        clear_logs();
        sq = '{8'h02, 8'h00, 8'hAA, 8'h55, 8'h00};
        gq = '{};
        pulse_start();
        send_stream(-1);
        n_tests++;
        if (wr_addr_q.size() != 2) begin
            n_fail++; $display("FAIL badcs_wcount: got %0d writes required 2", wr_addr_q.size());
        end else begin
            n_tests++;
            if (wr_addr_q[0] !== 11'd0 || wr_data_q[0] !== 8'hAA || wr_addr_q[1] !== 11'd1 || wr_data_q[1] !== 8'h55) begin
                n_fail++;
                $display("FAIL badcs_writes: got (%h,%h)(%h,%h) required (000,aa)(001,55)", wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
            end
        end
        n_tests++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL badcs_err: got %b required 1", err_out); end
        n_tests++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL badcs_done: got %b required 0", done_out); end
        n_tests++; if (cpu_hold_out !== 1'b0) begin n_fail++; $display("FAIL badcs_hold: got %b required 0", cpu_hold_out); end
    endtask

    task automatic test_len_too_big();
        clear_logs();
        sq = '{8'h01, 8'h08};
        gq = '{};
        pulse_start();
        n_tests++; if (done_out !== 1'b0 || err_out !== 1'b0) begin n_fail++; $display("FAIL big_flags_cleared: got done=%b err=%b required 0 0", done_out, err_out); end
        send_stream(-1);
        n_tests++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL big_err: got %b required 1", err_out); end
        n_tests++; if (byte_ready_out !== 1'b0) begin n_fail++; $display("FAIL big_ready: got %b required 0", byte_ready_out); end
        n_tests++; if (cpu_hold_out !== 1'b0) begin n_fail++; $display("FAIL big_hold: got %b required 0", cpu_hold_out); end
        repeat (3) @(negedge clk);
        n_tests++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL big_wcount: got %0d writes required 0", wr_addr_q.size()); end
        n_tests++; if (byte_ready_out !== 1'b0) begin n_fail++; $display("FAIL big_ready_later: got %b required 0", byte_ready_out); end
    endtask

    task automatic test_zero_len();
        clear_logs();
        sq = '{8'h00, 8'h00, 8'h00};
        gq = '{};
        pulse_start();
        send_stream(-1);
        n_tests++; if (done_out !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b required 1", done_out); end
        n_tests++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %b required 0", err_out); end
        n_tests++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL zero_wcount: got %0d writes required 0", wr_addr_q.size()); end
    endtask

    task automatic test_reset_mid_load();
        clear_logs();
        sq = '{8'h04, 8'h00, 8'h13, 8'h05};
        gq = '{};
        pulse_start();
        send_stream(-1);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({byte_ready_out, we_out, cpu_hold_out, done_out, err_out} !== 5'b0 || waddr_out !== '0 || wdata_out !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_outputs: got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h required all 0",
                     byte_ready_out, we_out, cpu_hold_out, done_out, err_out, waddr_out, wdata_out);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL midrst_wcount: got %0d writes required 2", wr_addr_q.size()); end
        n_tests++; if (byte_ready_out !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: ready got %b required 0", byte_ready_out); end
        clear_logs();
        sq    = '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
        exp_a = '{11'd0, 11'd1, 11'd2, 11'd3};
        exp_d = '{8'h13, 8'h05, 8'hA0, 8'h00};
        pulse_start();
        send_stream(-1);
        check_good_load("reload");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_bad_csum();
        test_len_too_big();
        test_zero_len();
        test_reset_mid_load();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
